adc_scan_spi_master: RTL and testbench
======================================

Name: adc_scan_spi_master

Overview:
Parametrised SPI master for the ADCx2S101/ADCx28S family of serial ADCs. It generates SCK internally from sys_clk and scans a maskable set of up to 8 channels round-robin. Each result is delivered as a one-cycle-valid word tagged with its channel. It replaces single-channel, externally-clocked capture in the sensor front end, and feeds sample buffers and DSP downstream.

Parameters:
SCK_HALF_DIV, 3, sys_clk cycles per SCK half-period (SCK = sys_clk / (2*SCK_HALF_DIV)); minimum 1.
RES_BITS, 8, converter resolution (8, 10 or 12).
N_CH, 2, number of scannable channels (1..8).
QUIET_HALVES, 2, SCK half-periods with CSN high between frames; minimum 1.

Ports:
sys_clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  scan enable (level).
ch_mask  in  N_CH  bit i=1 includes channel i in the scan.
SDI  in  1  ADC DOUT.
SCK  out  1  serial clock to the ADC; idles high.
CSN  out  1  ADC chip select, active low.
SDO  out  1  ADC DIN (control word).
data  out  RES_BITS  conversion result.
data_ch  out  3  channel of data.
data_valid  out  1  one-cycle pulse; data and data_ch are valid.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (or rst=1 in any state, including mid-frame), next edge: SCK=1, CSN=1, SDO=0, data=0, data_ch=0, data_valid=0, busy=0, state=IDLE, cur_ch=0. Priming flag set. The in-flight frame is abandoned and no result is emitted.
- Single clock domain. The half-period counter counts 0..SCK_HALF_DIV-1; every FSM timing step below is one half-period.

State machine:
- IDLE: stay here while en=0 or ch_mask==0.
  - Otherwise, sample ch_mask and compute next_ch = lowest set bit strictly above cur_ch, wrapping to the lowest set bit.
  - Load ctrl = {2'b00, next_ch[2:0], 3'b000}, set CSN=0, go to SETUP.
- SETUP: one half-period with SCK=1 and CSN=0, then SCK=0 (falling edge 1); go to LOW.
- LOW: at falling edge k (k=1..16), drive SDO = ctrl bit (8-k) for k<=8, else 0.
  - ADD2/ADD1/ADD0 therefore appear on falling edges 3/4/5.
  - After the half-period, SCK=1 (rising edge k); go to HIGH.
- HIGH: on the rising edge, shift SDI into the 16-bit rx register, MSB first.
  - k<16: after the half-period, SCK=0; go to LOW.
  - k=16: go to HOLD.
- HOLD: one half-period with SCK=1. Then CSN=1 and SDO=0; go to QUIET.
  - In the same cycle CSN rises: if the priming flag is clear, pulse data_valid with data = rx[11:12-RES_BITS] and data_ch = prev_ch.
  - Then clear the priming flag, set prev_ch = the channel just addressed, and set cur_ch = the channel just addressed.
- QUIET: hold for QUIET_HALVES half-periods.
  - If en=1 and ch_mask!=0, start the next frame exactly as the IDLE exit does.
  - Otherwise go to IDLE and set the priming flag.
- Pipelining: the address sent in frame N selects the conversion returned in frame N+1. The first frame after IDLE is a priming frame and produces no data_valid.
- en falling mid-frame: the frame completes and its result is emitted (if not priming), then IDLE.
- ch_mask changes mid-frame: they take effect only at the next frame start.
- ch_mask becoming 0: finish the current frame, then IDLE.
- Single set bit in ch_mask: the same channel repeats every frame.
- Frame period: SCK_HALF_DIV*(34+QUIET_HALVES) sys_clk cycles. With defaults and a 48 MHz sys_clk this is SCK = 8 MHz and 108 cycles per frame (444 ksps).
- Channel bits at positions >= N_CH are treated as 0.

Test Plan:
- Reset: apply rst=1 for 3 cycles with en=1 → SCK=1, CSN=1, SDO=0, data_valid=0, busy=0. Assert rst mid-frame (after rising edge 7) → the same values on the next cycle, no data_valid, and the next frame is a priming frame.
- Continuous, 2 channels: N_CH=2, ch_mask=2'b11, ADC model returns 0x0AB<<4 for ch0 and 0x0CD<<4 for ch1.
  - Required: the first frame emits no valid; then data alternates 0xAB/ch0 and 0xCD/ch1.
  - SDO carries 3'b000 / 3'b001 on falling edges 3..5.
  - Frame spacing is 108 cycles; each frame has 16 SCK falling edges.
- Mask gaps and wrap: N_CH=4, ch_mask=4'b1010 → addressed sequence 1,3,1,3; data_ch sequence 1,3,1,…. Change the mask to 4'b0100 mid-frame → the next address is 2 and the previous pending result is still tagged correctly.
- Resolution: RES_BITS=12 with the model returning 0x0ABC → data=0xABC. RES_BITS=10 → data=0x2AF.
- en drop: deassert en after rising edge 4 → the frame completes, data_valid pulses once, CSN stays 1, and busy falls after QUIET. Setting ch_mask=0 with en=1 keeps the block IDLE, with no SCK activity for 1000 cycles.
- Timing: check SCK_HALF_DIV=1 and 5. Every SCK high and low phase is exactly SCK_HALF_DIV cycles. CSN→first fall is SCK_HALF_DIV cycles. CSN is high for QUIET_HALVES*SCK_HALF_DIV cycles between frames.

Source files
------------

// File: rtl/adc_scan_spi_master.sv
// SPI master for ADCx2S101/ADCx28S converters: internally generated SCK,
// round-robin scan over a channel mask, one-frame address/result pipeline.
module adc_scan_spi_master #(
  parameter int SCK_HALF_DIV = 3,
  parameter int RES_BITS     = 8,
  parameter int N_CH         = 2,
  parameter int QUIET_HALVES = 2
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic                SDI,
  output logic                SCK,
  output logic                CSN,
  output logic                SDO,
  output logic [RES_BITS-1:0] data,
  output logic [2:0]          data_ch,
  output logic                data_valid,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, QUIET} state_t;

  localparam int HW = (SCK_HALF_DIV > 1) ? $clog2(SCK_HALF_DIV) : 1;
  localparam int KW = (QUIET_HALVES > 16) ? $clog2(QUIET_HALVES + 1) : 5;
  localparam logic [HW-1:0] HALF_LAST  = HW'(SCK_HALF_DIV - 1);
  localparam logic [KW-1:0] QUIET_LAST = KW'(QUIET_HALVES - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(16);

  state_t                state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [KW-1:0]         k_q, k_d;
  logic [7:0]            ctrl_q, ctrl_d;
  logic [11:0]           rx_q, rx_d;
  logic [2:0]            ch_q, ch_d;
  logic [2:0]            addr_q, addr_d;
  logic                  prime_q, prime_d;
  logic                  sck_q, sck_d;
  logic                  csn_q, csn_d;
  logic                  sdo_q, sdo_d;
  logic [RES_BITS-1:0]   data_q, data_d;
  logic [2:0]            data_ch_q, data_ch_d;
  logic                  dv_q, dv_d;

  logic [7:0] mask8;
  logic [2:0] nxt_above, nxt_low, next_ch, idx;
  logic       above_ok, start, half_done;

  // Round-robin pick: lowest set bit above the current channel, else wrap.
  always_comb begin
    mask8             = '0;
    mask8[N_CH-1:0]   = ch_mask;
    nxt_above         = '0;
    nxt_low           = '0;
    above_ok          = 1'b0;
    idx               = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'(7 - i);
      if (mask8[idx]) begin
        nxt_low = idx;
        if (idx > ch_q) begin
          nxt_above = idx;
          above_ok  = 1'b1;
        end
      end
    end
    next_ch   = above_ok ? nxt_above : nxt_low;
    start     = en && (mask8 != '0);
    half_done = (hcnt_q == HALF_LAST);
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = half_done ? '0 : hcnt_q + 1'b1;
    k_d       = k_q;
    ctrl_d    = ctrl_q;
    rx_d      = rx_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    prime_d   = prime_q;
    sck_d     = sck_q;
    csn_d     = csn_q;
    sdo_d     = sdo_q;
    data_d    = data_q;
    data_ch_d = data_ch_q;
    dv_d      = 1'b0;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (start) begin
          state_d = SETUP;
          csn_d   = 1'b0;
          ctrl_d  = {2'b00, next_ch, 3'b000};
          addr_d  = next_ch;
        end
      end
      SETUP: if (half_done) begin
        sck_d   = 1'b0;
        sdo_d   = ctrl_q[7];
        ctrl_d  = {ctrl_q[6:0], 1'b0};
        k_d     = KW'(1);
        state_d = LOW;
      end
      // Only the last 12 bits of the 16-bit frame are needed for any resolution.
      LOW: if (half_done) begin
        sck_d   = 1'b1;
        rx_d    = {rx_q[10:0], SDI};
        state_d = HIGH;
      end
      HIGH: if (half_done) begin
        if (k_q == K_LAST) begin
          state_d = HOLD;
        end else begin
          sck_d   = 1'b0;
          sdo_d   = ctrl_q[7];
          ctrl_d  = {ctrl_q[6:0], 1'b0};
          k_d     = k_q + 1'b1;
          state_d = LOW;
        end
      end
      HOLD: if (half_done) begin
        csn_d = 1'b1;
        sdo_d = 1'b0;
        if (!prime_q) begin
          dv_d      = 1'b1;
          data_d    = rx_q[11 -: RES_BITS];
          data_ch_d = ch_q;
        end
        prime_d = 1'b0;
        ch_d    = addr_q;
        k_d     = '0;
        state_d = QUIET;
      end
      QUIET: if (half_done) begin
        if (k_q == QUIET_LAST) begin
          k_d = '0;
          if (start) begin
            state_d = SETUP;
            csn_d   = 1'b0;
            ctrl_d  = {2'b00, next_ch, 3'b000};
            addr_d  = next_ch;
          end else begin
            state_d = IDLE;
            prime_d = 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      k_q       <= '0;
      ctrl_q    <= '0;
      rx_q      <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      prime_q   <= 1'b1;
      sck_q     <= 1'b1;
      csn_q     <= 1'b1;
      sdo_q     <= 1'b0;
      data_q    <= '0;
      data_ch_q <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      k_q       <= k_d;
      ctrl_q    <= ctrl_d;
      rx_q      <= rx_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      prime_q   <= prime_d;
      sck_q     <= sck_d;
      csn_q     <= csn_d;
      sdo_q     <= sdo_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
      dv_q      <= dv_d;
    end
  end

  assign SCK        = sck_q;
  assign CSN        = csn_q;
  assign SDO        = sdo_q;
  assign data       = data_q;
  assign data_ch    = data_ch_q;
  assign data_valid = dv_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scan_spi_master.sv
// Directed bench for adc_scan_spi_master: three parameter sets, each with a
// behavioural ADC (pipelined address -> result) and a timing monitor.
module tb_adc_scan_spi_master;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       en [3];
  logic [3:0] msk [3];

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  function automatic logic [15:0] adc_word(input int gi, input logic [2:0] ch);
    if (gi == 0) return (ch == 3'd0) ? 16'h0AB0 : (ch == 3'd1) ? 16'h0CD0 : 16'h0000;
    if (gi == 1) begin
      case (ch)
        3'd1:    return 16'h0ABC;
        3'd3:    return 16'h0123;
        3'd2:    return 16'h0456;
        default: return 16'h0FFF;
      endcase
    end
    return 16'h0ABC;
  endfunction

  for (genvar G = 0; G < 3; G++) begin : g
    localparam int D  = (G == 0) ? 3 : (G == 1) ? 1 : 5;
    localparam int RB = (G == 0) ? 8 : (G == 1) ? 12 : 10;
    localparam int NC = (G == 0) ? 2 : 4;
    localparam int QH = (G == 2) ? 3 : 2;

    logic          sck, csn, sdo, dv, busy;
    logic          sdi = 1'b0;
    logic [RB-1:0] data;
    logic [2:0]    dch;

    adc_scan_spi_master #(
      .SCK_HALF_DIV(D), .RES_BITS(RB), .N_CH(NC), .QUIET_HALVES(QH)
    ) dut (
      .sys_clk(sys_clk), .rst(rst), .en(en[G]), .ch_mask(msk[G][NC-1:0]),
      .SDI(sdi), .SCK(sck), .CSN(csn), .SDO(sdo), .data(data),
      .data_ch(dch), .data_valid(dv), .busy(busy)
    );

    int vcnt, fcnt, acnt, sck_edges, rises, falls, run, since_fall, hi_len, cyc;
    int first_fall, frame_per, quiet_len, falls_last, hmin, hmax, lmin, lmax;
    logic [11:0] vd [64];
    logic [2:0]  vc [64];
    logic [7:0]  alog [64];
    int          vtime [64];
    logic        prev_sck = 1'b1, prev_csn = 1'b1;
    logic [15:0] sh = '0;
    logic [7:0]  cap = '0;
    logic [2:0]  pend = '0;

    always @(negedge sys_clk) begin
      cyc++;
      if (rst) begin
        vcnt = 0; fcnt = 0; acnt = 0; sck_edges = 0; rises = 0; falls = 0;
        run = 0; since_fall = 0; hi_len = 0; first_fall = -1; frame_per = -1;
        quiet_len = -1; falls_last = -1; hmin = 999; hmax = 0; lmin = 999; lmax = 0;
      end else begin
        if (sck != prev_sck) sck_edges++;
        if (dv) begin
          if (vcnt < 64) begin
            vd[vcnt] = 12'(data); vc[vcnt] = dch; vtime[vcnt] = cyc;
          end
          vcnt++;
        end
        since_fall++;
        if (csn) hi_len++;
        if (!csn && prev_csn) begin
          frame_per = since_fall; since_fall = 0; quiet_len = hi_len; hi_len = 0;
          run = 0; falls = 0; rises = 0; cap = '0;
          sh = adc_word(G, pend);
        end else if (!csn && sck != prev_sck) begin
          if (!sck) begin
            falls++;
            if (falls == 1) first_fall = run;
            else begin
              if (run < hmin) hmin = run;
              if (run > hmax) hmax = run;
            end
            sdi = sh[15];
            sh  = sh << 1;
          end else begin
            rises++;
            if (run < lmin) lmin = run;
            if (run > lmax) lmax = run;
            if (rises <= 8) cap = {cap[6:0], sdo};
          end
          run = 0;
        end
        if (csn && !prev_csn) begin
          fcnt++;
          falls_last = falls;
          if (acnt < 64) alog[acnt] = cap;
          pend = cap[5:3];
          acnt++;
        end
        run++;
      end
      prev_sck = sck;
      prev_csn = csn;
    end
  end

  initial begin
    int v0, f0, a0, q, s0;
    logic [2:0] x;
    rst = 1'b1;
    en[0] = 1'b1; en[1] = 1'b0; en[2] = 1'b0;
    msk[0] = 4'b0011; msk[1] = 4'b0000; msk[2] = 4'b0000;
    repeat (3) step();
    check("rst_sck",  32'(g[0].sck), 1);
    check("rst_csn",  32'(g[0].csn), 1);
    check("rst_sdo",  32'(g[0].sdo), 0);
    check("rst_dv",   32'(g[0].dv), 0);
    check("rst_busy", 32'(g[0].busy), 0);
    check("rst_data", 32'(g[0].data), 0);
    check("rst_dch",  32'(g[0].dch), 0);
    rst = 1'b0;

    // continuous two-channel scan, default timing
    for (int t = 0; t < 3000 && g[0].vcnt < 4; t++) step();
    check("cont_wait",  32'(g[0].vcnt >= 4), 1);
    check("cont_prime", g[0].fcnt - g[0].vcnt, 1);
    check("cont_d0", 32'(g[0].vd[0]), 'hCD);
    check("cont_c0", 32'(g[0].vc[0]), 1);
    check("cont_d1", 32'(g[0].vd[1]), 'hAB);
    check("cont_c1", 32'(g[0].vc[1]), 0);
    check("cont_d2", 32'(g[0].vd[2]), 'hCD);
    check("cont_c2", 32'(g[0].vc[2]), 1);
    check("cont_a0", 32'(g[0].alog[0]), 'h08);
    check("cont_a1", 32'(g[0].alog[1]), 'h00);
    check("cont_vgap",  g[0].vtime[2] - g[0].vtime[1], 108);
    check("cont_per",   g[0].frame_per, 108);
    check("cont_falls", g[0].falls_last, 16);
    check("cont_first", g[0].first_fall, 3);
    check("cont_hmin",  g[0].hmin, 3);
    check("cont_hmax",  g[0].hmax, 3);
    check("cont_lmin",  g[0].lmin, 3);
    check("cont_lmax",  g[0].lmax, 3);
    check("cont_quiet", g[0].quiet_len, 6);

    // reset after rising edge 7 of a frame
    for (int t = 0; t < 500 && !(g[0].rises == 7 && !g[0].csn); t++) step();
    check("mid_wait", g[0].rises, 7);
    rst = 1'b1;
    step();
    check("mid_sck",  32'(g[0].sck), 1);
    check("mid_csn",  32'(g[0].csn), 1);
    check("mid_sdo",  32'(g[0].sdo), 0);
    check("mid_dv",   32'(g[0].dv), 0);
    check("mid_busy", 32'(g[0].busy), 0);
    step();
    rst = 1'b0;
    for (int t = 0; t < 1000 && g[0].fcnt < 2; t++) step();
    check("mid_frames", g[0].fcnt, 2);
    check("mid_prime",  g[0].vcnt, 1);
    check("mid_ch",     32'(g[0].vc[0]), 1);

    // en drop after rising edge 4
    for (int t = 0; t < 500 && !(g[0].rises == 4 && !g[0].csn); t++) step();
    check("drop_wait", g[0].rises, 4);
    v0 = g[0].vcnt; f0 = g[0].fcnt;
    en[0] = 1'b0;
    q = 0;
    for (int t = 0; t < 1000 && g[0].busy; t++) begin
      if (g[0].csn) q++;
      step();
    end
    check("drop_busy",   32'(g[0].busy), 0);
    check("drop_quiet",  q, 6);
    check("drop_valid",  g[0].vcnt - v0, 1);
    check("drop_frames", g[0].fcnt - f0, 1);
    check("drop_csn",    32'(g[0].csn), 1);

    // enabled with empty mask stays idle
    en[0] = 1'b1; msk[0] = 4'b0000;
    s0 = g[0].sck_edges;
    repeat (1000) step();
    check("mask0_sck",  g[0].sck_edges - s0, 0);
    check("mask0_busy", 32'(g[0].busy), 0);
    check("mask0_csn",  32'(g[0].csn), 1);
    en[0] = 1'b0;

    // 4 channels, gaps in mask, 12-bit, SCK_HALF_DIV=1
    rst = 1'b1; step(); step(); rst = 1'b0;
    en[1] = 1'b1; msk[1] = 4'b1010;
    for (int t = 0; t < 1000 && g[1].vcnt < 3; t++) step();
    check("gap_wait", 32'(g[1].vcnt >= 3), 1);
    check("gap_a0", 32'(g[1].alog[0]), 'h08);
    check("gap_a1", 32'(g[1].alog[1]), 'h18);
    check("gap_a2", 32'(g[1].alog[2]), 'h08);
    check("gap_a3", 32'(g[1].alog[3]), 'h18);
    check("gap_d0", 32'(g[1].vd[0]), 'hABC);
    check("gap_c0", 32'(g[1].vc[0]), 1);
    check("gap_d1", 32'(g[1].vd[1]), 'h123);
    check("gap_c1", 32'(g[1].vc[1]), 3);
    check("gap_d2", 32'(g[1].vd[2]), 'hABC);
    check("gap_c2", 32'(g[1].vc[2]), 1);
    check("d1_first", g[1].first_fall, 1);
    check("d1_hmin",  g[1].hmin, 1);
    check("d1_hmax",  g[1].hmax, 1);
    check("d1_lmin",  g[1].lmin, 1);
    check("d1_lmax",  g[1].lmax, 1);
    check("d1_quiet", g[1].quiet_len, 2);
    check("d1_per",   g[1].frame_per, 36);
    check("d1_falls", g[1].falls_last, 16);

    // mask change mid-frame
    for (int t = 0; t < 500 && !(g[1].rises == 7 && !g[1].csn); t++) step();
    check("chg_wait", g[1].rises, 7);
    a0 = g[1].acnt;
    x = (a0 % 2 == 0) ? 3'd1 : 3'd3;
    msk[1] = 4'b0100;
    for (int t = 0; t < 500 && g[1].vcnt < a0 + 2; t++) step();
    check("chg_vwait", 32'(g[1].vcnt >= a0 + 2), 1);
    check("chg_a_old", 32'(g[1].alog[a0]), 32'({2'b00, x, 3'b000}));
    check("chg_a_new", 32'(g[1].alog[a0 + 1]), 'h10);
    check("chg_a_rep", 32'(g[1].alog[a0 + 2]), 'h10);
    check("chg_c_old", 32'(g[1].vc[a0]), 32'(x));
    check("chg_d_old", 32'(g[1].vd[a0]), (x == 3'd1) ? 'hABC : 'h123);
    check("chg_c_new", 32'(g[1].vc[a0 + 1]), 2);
    check("chg_d_new", 32'(g[1].vd[a0 + 1]), 'h456);
    en[1] = 1'b0;

    // single channel, 10-bit, SCK_HALF_DIV=5, QUIET_HALVES=3
    rst = 1'b1; step(); step(); rst = 1'b0;
    en[2] = 1'b1; msk[2] = 4'b0001;
    for (int t = 0; t < 3000 && g[2].vcnt < 3; t++) step();
    check("r10_wait", 32'(g[2].vcnt >= 3), 1);
    check("r10_d0", 32'(g[2].vd[0]), 'h2AF);
    check("r10_c0", 32'(g[2].vc[0]), 0);
    check("r10_d1", 32'(g[2].vd[1]), 'h2AF);
    check("r10_c1", 32'(g[2].vc[1]), 0);
    check("r10_a0", 32'(g[2].alog[0]), 'h00);
    check("r10_a1", 32'(g[2].alog[1]), 'h00);
    check("d5_first", g[2].first_fall, 5);
    check("d5_hmin",  g[2].hmin, 5);
    check("d5_hmax",  g[2].hmax, 5);
    check("d5_lmin",  g[2].lmin, 5);
    check("d5_lmax",  g[2].lmax, 5);
    check("d5_quiet", g[2].quiet_len, 15);
    check("d5_per",   g[2].frame_per, 185);
    check("d5_falls", g[2].falls_last, 16);
    en[2] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
